// File: rtl/wb_dac_channel_pkg.sv
// Shared definitions for the DAC playback channel.
// Control-register bit positions match the per-channel control register
// used by the capture channels under the same WB DSP slave.
// Fetch FSM encodings are kept as plain constants for compatibility with
// existing register dumps.
package wb_dac_channel_pkg;

    // Control register bit positions
    localparam int CONTROL_REG_CHANNEL_ENABLE = 0;
    localparam int CONTROL_REG_SIGNED_DATA    = 1;

    // Fetch FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;

endpackage

// File: rtl/dac_data_disaggregation.sv
// Splits FIFO words into DAC samples, LSB sample first, one per strobe.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_flush          drop the held word and any load in flight, clear underflow
//   i_enable         channel enable; strobes are ignored while low
//   i_signed         samples are two's complement (converted to offset binary)
//   i_fifo_empty     FIFO has no word
//   i_fifo_data      FIFO registered read data (valid the cycle after a pop)
//   o_fifo_pop       pop one word from the FIFO
//   i_ready          DAC strobe, consumes one sample
//   o_data, o_valid  sample output and its one-cycle update pulse
//   o_underflow      sticky: strobe arrived with no sample held
module dac_data_disaggregation #(
    parameter int dw             = 32,
    parameter int DAC_DATA_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic                      i_enable,
    input  logic                      i_signed,
    input  logic                      i_fifo_empty,
    input  logic [dw-1:0]             i_fifo_data,
    output logic                      o_fifo_pop,
    input  logic                      i_ready,
    output logic [DAC_DATA_WIDTH-1:0] o_data,
    output logic                      o_valid,
    output logic                      o_underflow
);
    localparam int SPW = dw / DAC_DATA_WIDTH;
    localparam int IW  = (SPW > 1) ? $clog2(SPW) : 1;

    logic [dw-1:0]             r_word;
    logic [IW-1:0]             r_idx;
    logic                      r_full;
    logic                      r_pending;
    logic [DAC_DATA_WIDTH-1:0] r_data;
    logic                      r_valid;
    logic                      r_underflow;

    logic                      w_take;
    logic                      w_last;
    logic [DAC_DATA_WIDTH-1:0] w_sample;
    logic [DAC_DATA_WIDTH-1:0] w_conv;

    assign w_take   = i_enable & i_ready & r_full;
    assign w_last   = (r_idx == IW'(SPW - 1));
    assign w_sample = r_word[int'(r_idx)*DAC_DATA_WIDTH +: DAC_DATA_WIDTH];
    // Inverting the MSB maps two's complement onto offset binary.
    assign w_conv   = w_sample ^ {i_signed, {(DAC_DATA_WIDTH-1){1'b0}}};

    // Pop while the last sample is being consumed so the next word arrives
    // without a bubble; a load in flight blocks a second pop. r_full is never
    // set while r_pending, so load and take cannot collide.
    assign o_fifo_pop = i_enable & ~i_fifo_empty & ~r_pending &
                        (~r_full | (w_take & w_last));

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_underflow = r_underflow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word      <= '0;
            r_idx       <= '0;
            r_full      <= 1'b0;
            r_pending   <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_flush) begin
                r_idx       <= '0;
                r_full      <= 1'b0;
                r_pending   <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                r_pending <= o_fifo_pop;
                if (r_pending) begin
                    r_word <= i_fifo_data;
                    r_idx  <= '0;
                    r_full <= 1'b1;
                end else if (w_take) begin
                    r_data  <= w_conv;
                    r_valid <= 1'b1;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_full <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                if (i_enable && i_ready && !r_full) begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/fifo.sv
// Synchronous word FIFO with registered read data and a synchronous flush.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_flush             empty the FIFO (pointers and count cleared)
//   i_push, i_wr_data   write one word (ignored when full)
//   i_pop               read one word; o_rd_data valid the following cycle
//   o_count             words currently stored (0..DEPTH)
//   o_empty, o_full     status flags
module fifo #(
    parameter int dw    = 32,
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [dw-1:0]              i_wr_data,
    input  logic                       i_pop,
    output logic [dw-1:0]              o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [dw-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;
    logic [dw-1:0]  r_rd_data;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_rd_data = r_rd_data;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_data <= r_mem[r_rptr];
                r_rptr    <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/wb_dac_channel.sv
// DAC playback channel: fetches SRAM words in bursts via the request/grant
// arbiter, buffers them in a FIFO and plays them out one sample per strobe.
// Ports:
//   wb_clk, wb_rst                clock, asynchronous active-low reset
//   master_enable, control        global enable; bit0 channel enable, signed-data bit
//   fifo_number_samples_terminal  burst length in words (0 treated as 1)
//   grant                         arbiter grant
//   sram_data_in/sram_data_valid  burst data beats
//   dac_data_ready                DAC sample strobe
//   sram_start                    bus request, held until the burst completes
//   dac_data_out/dac_data_valid   sample (offset binary) and update pulse
//   fifo_empty, underflow         status
module wb_dac_channel
    import wb_dac_channel_pkg::*;
#(
    parameter int dw             = 32,
    parameter int DAC_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst,
    input  logic                          master_enable,
    input  logic [dw-1:0]                 control,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_number_samples_terminal,
    input  logic                          grant,
    input  logic [dw-1:0]                 sram_data_in,
    input  logic                          sram_data_valid,
    input  logic                          dac_data_ready,
    output logic                          sram_start,
    output logic [DAC_DATA_WIDTH-1:0]     dac_data_out,
    output logic                          dac_data_valid,
    output logic                          fifo_empty,
    output logic                          underflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    r_state;
    logic [CW-1:0] r_beat;

    logic          w_enable;
    logic [CW-1:0] w_term;
    logic [CW-1:0] w_free;
    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_full;
    logic          w_push;
    logic          w_pop;
    logic [dw-1:0] w_fifo_rd;
    logic          w_unused;

    assign w_enable = master_enable & control[CONTROL_REG_CHANNEL_ENABLE];
    assign w_term   = (fifo_number_samples_terminal == '0) ? CW'(1)
                                                           : fifo_number_samples_terminal;
    assign w_free   = CW'(FIFO_DEPTH) - w_fifo_count;

    assign sram_start = (r_state == ST_REQ) || (r_state == ST_XFER);
    // Beats arriving while disabled finish the burst but are not stored.
    assign w_push     = (r_state == ST_XFER) & sram_data_valid & w_enable;
    assign w_unused   = ^{control, w_fifo_full};

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_beat <= '0;
                    if (w_enable && (w_free >= w_term)) begin
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!w_enable) begin
                        r_state <= ST_IDLE;
                    end else if (grant) begin
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (sram_data_valid) begin
                        if (r_beat == w_term - 1'b1) begin
                            r_state <= ST_IDLE;
                            r_beat  <= '0;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    fifo #(
        .dw    (dw),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (wb_clk),
        .i_rst_n   (wb_rst),
        .i_flush   (~w_enable),
        .i_push    (w_push),
        .i_wr_data (sram_data_in),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_rd),
        .o_count   (w_fifo_count),
        .o_empty   (fifo_empty),
        .o_full    (w_fifo_full)
    );

    dac_data_disaggregation #(
        .dw             (dw),
        .DAC_DATA_WIDTH (DAC_DATA_WIDTH)
    ) u_unpack (
        .i_clk        (wb_clk),
        .i_rst_n      (wb_rst),
        .i_flush      (~w_enable),
        .i_enable     (w_enable),
        .i_signed     (control[CONTROL_REG_SIGNED_DATA]),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (w_fifo_rd),
        .o_fifo_pop   (w_pop),
        .i_ready      (dac_data_ready),
        .o_data       (dac_data_out),
        .o_valid      (dac_data_valid),
        .o_underflow  (underflow)
    );
endmodule

// File: tb/tb_wb_dac_channel.sv
// Randomized self-checking bench for wb_dac_channel. A behavioural SRAM
// responder serves bursts; a queue model tracks delivered samples, their
// availability time and the expected output stream.
module tb_wb_dac_channel;
    localparam int SPW = 4;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b0;
    logic        master_enable = 1'b0;
    logic [31:0] control = '0;
    logic [4:0]  term = 5'd4;
    logic        grant = 1'b0;
    logic [31:0] sram_data_in = '0;
    logic        sram_data_valid = 1'b0;
    logic        dac_data_ready = 1'b0;
    logic        sram_start;
    logic [7:0]  dac_data_out;
    logic        dac_data_valid;
    logic        fifo_empty;
    logic        underflow;

    always #5 wb_clk = ~wb_clk;

    wb_dac_channel #(
        .dw             (32),
        .DAC_DATA_WIDTH (8),
        .FIFO_DEPTH     (16)
    ) dut (
        .wb_clk                       (wb_clk),
        .wb_rst                       (wb_rst),
        .master_enable                (master_enable),
        .control                      (control),
        .fifo_number_samples_terminal (term),
        .grant                        (grant),
        .sram_data_in                 (sram_data_in),
        .sram_data_valid              (sram_data_valid),
        .dac_data_ready               (dac_data_ready),
        .sram_start                   (sram_start),
        .dac_data_out                 (dac_data_out),
        .dac_data_valid               (dac_data_valid),
        .fifo_empty                   (fifo_empty),
        .underflow                    (underflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int         edge_n = 0;
    int         dq[$];          // delivery edge of each word not yet playable
    logic [7:0] sq[$];          // delivered samples in play order (raw)
    int         ready_words = 0;
    int         consumed = 0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_out = '0;
    logic       uf = 1'b0;

    // SRAM responder state
    int          rs = 0;        // 0 idle, 1 grant delay, 2 beats, 3 burst end
    int          gdly = 0;
    int          beats_left = 0;
    int          bursts = 0;
    int          fixed_gdly = -1;
    logic        hold_grant = 1'b0;
    logic [31:0] dwords[$];
    int          last_strobe = -100;

    function automatic int ready_at(input int e);
        int r = ready_words;
        foreach (dq[i]) if (dq[i] <= e - 3) r++;
        return r * SPW - consumed;
    endfunction

    function automatic int pending_samples();
        return (ready_words + dq.size()) * SPW - consumed;
    endfunction

    task automatic model_flush();
        dq.delete();
        sq.delete();
        ready_words = 0;
        consumed = 0;
        uf = 1'b0;
    endtask

    task automatic model_edge();
        logic en;
        en = master_enable & control[0];
        exp_valid = 1'b0;
        if (!en || !wb_rst) begin
            model_flush();
        end else begin
            while (dq.size() > 0 && dq[0] <= edge_n - 3) begin
                void'(dq.pop_front());
                ready_words++;
            end
            if (dac_data_ready) begin
                if (ready_words * SPW - consumed > 0) begin
                    exp_out = sq.pop_front() ^ (control[1] ? 8'h80 : 8'h00);
                    exp_valid = 1'b1;
                    consumed++;
                end else begin
                    uf = 1'b1;
                end
            end
            if (sram_data_valid) begin
                dq.push_back(edge_n);
                for (int k = 0; k < SPW; k++) sq.push_back(sram_data_in[k*8 +: 8]);
            end
        end
    endtask

    task automatic responder();
        logic en_now;
        int   eff;
        en_now = master_enable & control[0];
        eff = (term == 0) ? 1 : int'(term);
        grant = 1'b0;
        sram_data_valid = 1'b0;
        case (rs)
            2: begin
                chk("start_hold", 32'(sram_start), 32'd1);
                if ($urandom_range(0, 2) != 0) begin
                    sram_data_valid = 1'b1;
                    sram_data_in = (dwords.size() > 0) ? dwords.pop_front() : $urandom();
                    beats_left--;
                    if (beats_left == 0) rs = 3;
                end
            end
            3: begin
                chk("start_drop", 32'(sram_start), 32'd0);
                rs = 0;
                bursts++;
            end
            default: ;
        endcase
        if (rs == 0 && sram_start && en_now && !hold_grant) begin
            gdly = (fixed_gdly >= 0) ? fixed_gdly : int'($urandom_range(0, 3));
            fixed_gdly = -1;
            rs = 1;
        end
        if (rs == 1) begin
            if (!sram_start || !en_now || hold_grant) begin
                rs = 0;
            end else if (gdly == 0) begin
                grant = 1'b1;
                beats_left = eff;
                rs = 2;
            end else begin
                gdly--;
            end
        end
    endtask

    task automatic step();
        @(posedge wb_clk);
        edge_n++;
        model_edge();
        @(negedge wb_clk);
        chk("valid", 32'(dac_data_valid), 32'(exp_valid));
        chk("dout", 32'(dac_data_out), 32'(exp_out));
        chk("uflow", 32'(underflow), 32'(uf));
        dac_data_ready = 1'b0;
        responder();
        #1;
        if (dut.w_push) chk("push_full", 32'(dut.w_fifo_full), 32'd0);
    endtask

    task automatic quiesce();
        int n = 0;
        hold_grant = 1'b1;
        while (rs != 0 && n < 200) begin
            step();
            n++;
        end
        if (rs != 0) chk("quiesce_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_phase(input int ncyc, input logic [4:0] t, input logic sgn);
        int e;
        term = t;
        control = {30'd0, sgn, 1'b1};
        master_enable = 1'b1;
        hold_grant = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            e = edge_n + 1;
            if (e - last_strobe >= 3) begin
                if (ready_at(e) > 0 && $urandom_range(0, 1) == 1) begin
                    dac_data_ready = 1'b1;
                    last_strobe = e;
                end else if (pending_samples() == 0 && $urandom_range(0, 15) == 0) begin
                    dac_data_ready = 1'b1;
                    last_strobe = e;
                end
            end
            step();
        end
        quiesce();
    endtask

    initial begin
        int n;
        int b0;
        // Reset state
        repeat (2) @(negedge wb_clk);
        chk("rst_start", 32'(sram_start), 32'd0);
        chk("rst_valid", 32'(dac_data_valid), 32'd0);
        chk("rst_dout", 32'(dac_data_out), 32'd0);
        chk("rst_uflow", 32'(underflow), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        wb_rst = 1'b1;
        step();

        // Basic burst plus unpack order, unsigned
        dwords.push_back(32'h04030201);
        dwords.push_back(32'h08070605);
        dwords.push_back(32'h0C0B0A09);
        dwords.push_back(32'h100F0E0D);
        dwords.push_back(32'h44332211);
        fixed_gdly = 2;
        term = 5'd4;
        control = 32'h1;
        master_enable = 1'b1;
        step();
        chk("req_rise", 32'(sram_start), 32'd1);
        run_phase(300, 5'd4, 1'b0);
        run_phase(150, 5'd0, 1'b0);

        // Underflow with no data, cleared by disable
        master_enable = 1'b0;
        repeat (2) step();
        chk("flush_empty", 32'(fifo_empty), 32'd1);
        master_enable = 1'b1;
        control = 32'h1;
        repeat (4) step();
        dac_data_ready = 1'b1;
        step();
        chk("uf_set", 32'(underflow), 32'd1);
        chk("uf_novalid", 32'(dac_data_valid), 32'd0);
        step();
        master_enable = 1'b0;
        step();
        chk("uf_clear", 32'(underflow), 32'd0);
        dac_data_ready = 1'b1;
        step();
        chk("uf_dis_ignored", 32'(underflow), 32'd0);

        // Signed conversion
        dwords.push_back(32'h7F80FF00);
        run_phase(300, 5'd5, 1'b1);
        run_phase(250, 5'd16, 1'b1);

        // Refill threshold: FIFO holds 9 words, terminal 8
        master_enable = 1'b0;
        repeat (2) step();
        term = 5'd10;
        control = 32'h1;
        hold_grant = 1'b0;
        master_enable = 1'b1;
        b0 = bursts;
        n = 0;
        while (bursts == b0 && n < 200) begin step(); n++; end
        chk("fill_done", 32'(bursts - b0), 32'd1);
        hold_grant = 1'b1;
        term = 5'd8;
        repeat (6) begin step(); chk("no_req", 32'(sram_start), 32'd0); end
        for (int k = 0; k < 4; k++) begin
            dac_data_ready = 1'b1;
            step();
            chk("no_req_strobe", 32'(sram_start), 32'd0);
            if (k < 3) repeat (2) step();
        end
        step();
        chk("refill_req", 32'(sram_start), 32'd1);
        hold_grant = 1'b0;
        repeat (40) step();
        quiesce();

        // Disable in the middle of a burst
        master_enable = 1'b0;
        repeat (2) step();
        term = 5'd4;
        hold_grant = 1'b0;
        master_enable = 1'b1;
        n = 0;
        while (!(rs == 2 && beats_left == 2) && n < 100) begin step(); n++; end
        chk("mid_xfer_reached", 32'(rs == 2 && beats_left == 2), 32'd1);
        master_enable = 1'b0;
        n = 0;
        while (rs != 0 && n < 100) begin step(); n++; end
        chk("burst_finished", 32'(rs), 32'd0);
        chk("dis_empty", 32'(fifo_empty), 32'd1);
        for (int k = 0; k < 3; k++) begin dac_data_ready = 1'b1; repeat (3) step(); end

        // Set underflow, then async reset in the middle of a burst
        master_enable = 1'b1;
        step();
        dac_data_ready = 1'b1;
        step();
        chk("uf_pre_rst", 32'(underflow), 32'd1);
        n = 0;
        while (!(rs == 2 && beats_left < 4) && n < 100) begin step(); n++; end
        #2 wb_rst = 1'b0;
        #1;
        chk("arst_start", 32'(sram_start), 32'd0);
        chk("arst_valid", 32'(dac_data_valid), 32'd0);
        chk("arst_dout", 32'(dac_data_out), 32'd0);
        chk("arst_uflow", 32'(underflow), 32'd0);
        chk("arst_empty", 32'(fifo_empty), 32'd1);
        model_flush();
        exp_out = '0;
        rs = 0;
        master_enable = 1'b0;
        grant = 1'b0;
        sram_data_valid = 1'b0;
        step();
        wb_rst = 1'b1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
